// File: rtl/axil_cfg_seq_pkg.sv
// Shared definitions for the AXI4-Lite configuration sequencer: FSM state
// encoding and AXI response codes.
package axil_cfg_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrAddrData,
        StWrResp,
        StRdAddr,
        StRdData,
        StFinish
    } cfg_seq_state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_cfg_sequencer.sv
// AXI4-Lite master that writes NUM_REGS configuration words to consecutive
// word addresses starting at BASE_ADDR, one transaction at a time.
// Optional feature: define AXIL_CFG_READBACK_EN to read every register back
// after the writes and flag any data or response mismatch in err.
module axil_cfg_sequencer
    import axil_cfg_seq_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS           = 4,
    parameter logic [63:0] BASE_ADDR          = 64'h0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,

    input  logic                          start,
    input  logic [NUM_REGS*32-1:0]        cfg_data,
    output logic                          busy,
    output logic                          done,
    output logic                          err,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic [2:0]                    M_AXI_AWPROT,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,

    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]                    M_AXI_WSTRB,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,

    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,

    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,

    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int unsigned    IdxW    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REGS - 1);

    cfg_seq_state_e             state_q, state_d;
    logic [NUM_REGS*32-1:0]     shadow_q, shadow_d;
    logic [IdxW-1:0]            idx_q, idx_d;
    logic                       err_q, err_d;
    // AW and W complete independently; each flag remembers its own handshake.
    logic                       aw_done_q, aw_done_d;
    logic                       w_done_q, w_done_d;

    logic                          aw_hs, w_hs;
    logic [31:0]                   cur_word;
    logic [C_M_AXI_ADDR_WIDTH-1:0] cur_addr;

    assign aw_hs    = M_AXI_AWVALID && M_AXI_AWREADY;
    assign w_hs     = M_AXI_WVALID && M_AXI_WREADY;
    assign cur_word = shadow_q[int'(idx_q)*32 +: 32];
    assign cur_addr = C_M_AXI_ADDR_WIDTH'(BASE_ADDR + 64'({idx_q, 2'b00}));

    assign M_AXI_AWPROT = 3'b000;
    assign M_AXI_ARPROT = 3'b000;
    assign M_AXI_WSTRB  = 4'hF;
    assign err          = err_q;

    // State and datapath registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q   <= StIdle;
            shadow_q  <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        idx_d     = idx_q;
        err_d     = err_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d  = cfg_data;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrAddrData;
                end
            end
            StWrAddrData: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StWrResp;
                end
            end
            StWrResp: begin
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != AXI_RESP_OKAY) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else if (idx_q == LastIdx) begin
`ifdef AXIL_CFG_READBACK_EN
                        idx_d   = '0;
                        state_d = StRdAddr;
`else
                        state_d = StFinish;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StWrAddrData;
                    end
                end
            end
`ifdef AXIL_CFG_READBACK_EN
            StRdAddr: begin
                if (M_AXI_ARREADY) state_d = StRdData;
            end
            StRdData: begin
                if (M_AXI_RVALID) begin
                    if ((M_AXI_RRESP != AXI_RESP_OKAY) ||
                        (M_AXI_RDATA != C_M_AXI_DATA_WIDTH'(cur_word))) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else if (idx_q == LastIdx) begin
                        state_d = StFinish;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StRdAddr;
                    end
                end
            end
`endif
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Channel outputs and status decoded from the current state.
    always_comb begin
        M_AXI_AWADDR  = '0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WDATA   = '0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        M_AXI_ARADDR  = '0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_q)
            StWrAddrData: begin
                M_AXI_AWADDR  = cur_addr;
                M_AXI_WDATA   = C_M_AXI_DATA_WIDTH'(cur_word);
                M_AXI_AWVALID = !aw_done_q;
                M_AXI_WVALID  = !w_done_q;
                busy          = 1'b1;
            end
            StWrResp: begin
                M_AXI_BREADY = 1'b1;
                busy         = 1'b1;
            end
`ifdef AXIL_CFG_READBACK_EN
            StRdAddr: begin
                M_AXI_ARADDR  = cur_addr;
                M_AXI_ARVALID = 1'b1;
                busy          = 1'b1;
            end
            StRdData: begin
                M_AXI_RREADY = 1'b1;
                busy         = 1'b1;
            end
`endif
            StFinish: done = 1'b1;
            default: ;
        endcase
    end

`ifndef AXIL_CFG_READBACK_EN
    // Read channel inputs are ignored when readback is compiled out.
    logic unused_rd;
    assign unused_rd = ^{M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID};
`endif

endmodule

// File: tb/tb_axil_cfg_sequencer.sv
// Directed bench for axil_cfg_sequencer with a small AXI4-Lite slave model.
// Expectations follow AXIL_CFG_READBACK_EN when it is defined for the build.
module tb_axil_cfg_sequencer;
    import axil_cfg_seq_pkg::*;

`ifdef AXIL_CFG_READBACK_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] cfg;
    logic         busy, done, err;
    logic [31:0]  m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]   m_awprot, m_arprot;
    logic [3:0]   m_wstrb;
    logic         m_awvalid, m_awready, m_wvalid, m_wready;
    logic [1:0]   m_bresp, m_rresp;
    logic         m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

    always #5 clk = ~clk;

    axil_cfg_sequencer #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .NUM_REGS(4),
        .BASE_ADDR(64'h0)
    ) dut (
        .ACLK(clk), .ARESETN(rst_n),
        .start(start), .cfg_data(cfg), .busy(busy), .done(done), .err(err),
        .M_AXI_AWADDR(m_awaddr), .M_AXI_AWPROT(m_awprot),
        .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
        .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb),
        .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready),
        .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready),
        .M_AXI_ARADDR(m_araddr), .M_AXI_ARPROT(m_arprot),
        .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
        .M_AXI_RDATA(m_rdata), .M_AXI_RRESP(m_rresp),
        .M_AXI_RVALID(m_rvalid), .M_AXI_RREADY(m_rready)
    );

    // Slave knobs
    int   aw_delay, w_delay, berr_idx, stuck_idx;
    logic b_hold, mon_clr;

    // Slave state and monitors
    logic [31:0] mem [16];
    int          wr_cnt [16];
    int          aw_cyc, w_cyc, ar_cyc, ar_hs_cnt, done_cnt, viol, bad_attr;
    int          aw_wait_q, w_wait_q;
    logic        aw_pend, w_pend, aw_stall, w_stall, ar_stall;
    logic [31:0] aw_addr_q, w_data_q;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [31:0] wr_addr_sel, wr_data_sel;

    int n_vec = 0;
    int n_miss = 0;

    assign m_awready   = (aw_wait_q >= aw_delay);
    assign m_wready    = (w_wait_q >= w_delay);
    assign m_arready   = 1'b1;
    assign aw_hs       = m_awvalid && m_awready;
    assign w_hs        = m_wvalid && m_wready;
    assign b_hs        = m_bvalid && m_bready;
    assign ar_hs       = m_arvalid && m_arready;
    assign r_hs        = m_rvalid && m_rready;
    assign wr_addr_sel = aw_pend ? aw_addr_q : m_awaddr;
    assign wr_data_sel = w_pend ? w_data_q : m_wdata;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_bvalid  <= 1'b0;
            m_bresp   <= 2'b00;
            m_rvalid  <= 1'b0;
            m_rdata   <= '0;
            m_rresp   <= 2'b00;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            aw_wait_q <= 0;
            w_wait_q  <= 0;
            aw_stall  <= 1'b0;
            w_stall   <= 1'b0;
            ar_stall  <= 1'b0;
        end else if (mon_clr) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]    <= '0;
                wr_cnt[i] <= 0;
            end
            aw_cyc <= 0; w_cyc <= 0; ar_cyc <= 0; ar_hs_cnt <= 0;
            done_cnt <= 0; viol <= 0; bad_attr <= 0;
        end else begin
            if (m_awvalid) aw_cyc <= aw_cyc + 1;
            if (m_wvalid)  w_cyc  <= w_cyc + 1;
            if (m_arvalid) ar_cyc <= ar_cyc + 1;
            if (done)      done_cnt <= done_cnt + 1;
            // A VALID that was stalled last cycle must still be high now.
            if ((aw_stall && !m_awvalid) || (w_stall && !m_wvalid) || (ar_stall && !m_arvalid))
                viol <= viol + 1;
            aw_stall <= m_awvalid && !m_awready;
            w_stall  <= m_wvalid && !m_wready;
            ar_stall <= m_arvalid && !m_arready;
            if ((aw_hs && m_awprot != 3'b0) || (w_hs && m_wstrb != 4'hF) ||
                (ar_hs && m_arprot != 3'b0))
                bad_attr <= bad_attr + 1;

            if (aw_hs) aw_wait_q <= 0;
            else if (m_awvalid) aw_wait_q <= aw_wait_q + 1;
            if (w_hs) w_wait_q <= 0;
            else if (m_wvalid) w_wait_q <= w_wait_q + 1;

            if (aw_hs) begin aw_pend <= 1'b1; aw_addr_q <= m_awaddr; end
            if (w_hs)  begin w_pend  <= 1'b1; w_data_q  <= m_wdata;  end
            if ((aw_pend || aw_hs) && (w_pend || w_hs) && !m_bvalid && !b_hold) begin
                wr_cnt[wr_addr_sel[5:2]] <= wr_cnt[wr_addr_sel[5:2]] + 1;
                mem[wr_addr_sel[5:2]] <= (int'(wr_addr_sel[5:2]) == stuck_idx) ? 32'h0
                                                                                : wr_data_sel;
                m_bvalid <= 1'b1;
                m_bresp  <= (int'(wr_addr_sel[5:2]) == berr_idx) ? AXI_RESP_SLVERR
                                                                 : AXI_RESP_OKAY;
                aw_pend  <= 1'b0;
                w_pend   <= 1'b0;
            end
            if (b_hs) m_bvalid <= 1'b0;

            if (ar_hs) begin
                m_rvalid  <= 1'b1;
                m_rdata   <= mem[m_araddr[5:2]];
                m_rresp   <= AXI_RESP_OKAY;
                ar_hs_cnt <= ar_hs_cnt + 1;
            end
            if (r_hs) m_rvalid <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk); mon_clr = 1'b1;
        @(negedge clk); mon_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!done && i < budget) begin
            @(negedge clk);
            i++;
        end
        check_eq("done_seen", done, 1);
    endtask

    task automatic run_seq(input logic [127:0] c, input logic exp_err);
        @(negedge clk); start = 1'b1; cfg = c;
        @(negedge clk); start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        wait_done(300);
        check_eq("err_at_done", err, exp_err);
        check_eq("busy_in_finish", busy, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);
    endtask

    task automatic check_outputs_idle(input string tag);
        check_eq({tag, "_awvalid"}, m_awvalid, 0);
        check_eq({tag, "_wvalid"},  m_wvalid, 0);
        check_eq({tag, "_bready"},  m_bready, 0);
        check_eq({tag, "_arvalid"}, m_arvalid, 0);
        check_eq({tag, "_rready"},  m_rready, 0);
        check_eq({tag, "_busy"},    busy, 0);
        check_eq({tag, "_done"},    done, 0);
        check_eq({tag, "_awaddr"},  m_awaddr, 0);
        check_eq({tag, "_wdata"},   m_wdata, 0);
        check_eq({tag, "_state"},   dut.state_q, StIdle);
    endtask

    localparam logic [127:0] C1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] C2 = {32'hCAFE0003, 32'hBEEF0002, 32'h12345678, 32'h0000ABCD};
    localparam logic [127:0] C3 = {32'hA5A5_0044, 32'h5A5A_0033, 32'h0F0F_0022, 32'hF0F0_0011};
    localparam logic [127:0] C4 = {32'hFFFF_FFFF, 32'hEEEE_EEEE, 32'hDDDD_DDDD, 32'hCCCC_CCCC};

    initial begin
        logic [127:0] c;
        rst_n = 1'b0; start = 1'b0; cfg = '0; mon_clr = 1'b0; b_hold = 1'b0;
        aw_delay = 0; w_delay = 0; berr_idx = -1; stuck_idx = -1;
        repeat (3) @(negedge clk);
        check_outputs_idle("reset");
        check_eq("reset_err", err, 0);
        rst_n = 1'b1;
        clear_mon();

        // Zero-wait slave, nominal sequence
        run_seq(C1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t1_mem%0d", i), mem[i], i + 1);
            check_eq($sformatf("t1_wrcnt%0d", i), wr_cnt[i], 1);
        end
        check_eq("t1_aw_cycles", aw_cyc, 4);
        check_eq("t1_w_cycles", w_cyc, 4);
        check_eq("t1_ar_reads", ar_hs_cnt, 4 * RB);
        check_eq("t1_done_cnt", done_cnt, 1);

        // AWREADY three cycles late, WREADY immediate
        clear_mon();
        aw_delay = 3;
        run_seq(C2, 1'b0);
        check_eq("t2_aw_cycles", aw_cyc, 16);
        check_eq("t2_w_cycles", w_cyc, 4);
        c = C2;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2_mem%0d", i), mem[i], c[i*32 +: 32]);
            check_eq($sformatf("t2_wrcnt%0d", i), wr_cnt[i], 1);
        end

        // WREADY two cycles late, AWREADY immediate
        clear_mon();
        aw_delay = 0; w_delay = 2;
        run_seq(C1, 1'b0);
        check_eq("t2b_aw_cycles", aw_cyc, 4);
        check_eq("t2b_w_cycles", w_cyc, 12);
        check_eq("t2b_mem3", mem[3], 4);
        w_delay = 0;

        // SLVERR on register 2
        clear_mon();
        berr_idx = 2;
        run_seq(C1, 1'b1);
        check_eq("t3_wrcnt2", wr_cnt[2], 1);
        check_eq("t3_wrcnt3", wr_cnt[3], 0);
        check_eq("t3_ar_cycles", ar_cyc, 0);
        berr_idx = -1;
        repeat (2) @(negedge clk);
        check_eq("t3_err_sticky", err, 1);
        rst_n = 1'b0;
        #1;
        check_eq("t3_err_async_clear", err, 0);
        @(negedge clk); rst_n = 1'b1;

        // Register 1 reads back as zero
        clear_mon();
        stuck_idx = 1;
        run_seq(C1, RB[0]);
        check_eq("t4_mem1_stuck", mem[1], 0);
        check_eq("t4_ar_reads", ar_hs_cnt, 2 * RB);
        check_eq("t4_ar_cycles", ar_cyc, 2 * RB);
        stuck_idx = -1;

        // Start pulse while busy is ignored
        clear_mon();
        aw_delay = 1;
        @(negedge clk); start = 1'b1; cfg = C3;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; cfg = C4;
        @(negedge clk); start = 1'b0; cfg = '0;
        wait_done(300);
        check_eq("t5_err", err, 0);
        repeat (4) @(negedge clk);
        check_eq("t5_done_cnt", done_cnt, 1);
        c = C3;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t5_mem%0d", i), mem[i], c[i*32 +: 32]);
            check_eq($sformatf("t5_wrcnt%0d", i), wr_cnt[i], 1);
        end
        check_eq("t5_state", dut.state_q, StIdle);
        aw_delay = 0;

        // Reset while waiting for a write response
        clear_mon();
        b_hold = 1'b1;
        @(negedge clk); start = 1'b1; cfg = C1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50 && !m_bready; i++) @(negedge clk);
        check_eq("t6_in_wr_resp", m_bready, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_idle("t6_rst");
        b_hold = 1'b0;
        rst_n = 1'b1;
        clear_mon();
        run_seq(C2, 1'b0);
        c = C2;
        check_eq("t6_recover_mem0", mem[0], c[31:0]);
        check_eq("t6_recover_wrcnt0", wr_cnt[0], 1);
        check_eq("t6_recover_mem3", mem[3], c[127:96]);

        check_eq("valid_drop_violations", viol, 0);
        check_eq("bad_prot_strb", bad_attr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/axil_cfg_sequencer.md
AXIL_CFG_SEQUENCER -- requirements
Module: axil_cfg_sequencer

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI4-Lite data width (32 only).
REQ-003 SHALL have parameter NUM_REGS, default 4: registers programmed per sequence (1..16).
REQ-004 SHALL have parameter BASE_ADDR, default 0: address of register 0.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports: ACLK input, 1 bit, clock; ARESETN input, 1 bit, reset.
REQ-006 start  input  1  pulse; begins a sequence when idle.
REQ-007 cfg_data  input  NUM_REGS*32  register values; reg i = bits [32i+31:32i].
REQ-008 busy / done / err  output  1 each  sequence active / one-cycle completion pulse / sticky failure flag.
REQ-009 M_AXI_AWADDR, AWPROT[2:0], AWVALID out; AWREADY in: write-address channel.
REQ-010 M_AXI_WDATA, WSTRB[3:0], WVALID out; WREADY in: write-data channel.
REQ-011 M_AXI_BRESP[1:0], BVALID in; BREADY out: write-response channel.
REQ-012 M_AXI_ARADDR, ARPROT[2:0], ARVALID out; ARREADY in: read-address channel.
REQ-013 M_AXI_RDATA, RRESP[1:0], RVALID in; RREADY out: read-data channel.

Function
REQ-014 SHALL use FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, FINISH.
REQ-015 IDLE with start=1: SHALL capture cfg_data into a shadow register, clear err, set index=0, go to WR_ADDR_DATA; busy=1 from the next cycle.
REQ-016 start while busy SHALL be ignored; shadow SHALL NOT change mid-sequence.
REQ-017 Address for index i SHALL be BASE_ADDR + 4*i, truncated to C_M_AXI_ADDR_WIDTH; AWPROT=ARPROT=0; WSTRB=4'hF.
REQ-018 WR_ADDR_DATA: AWVALID and WVALID SHALL assert together. Each SHALL drop the cycle after its own handshake and SHALL stay high until that handshake. The state SHALL exit to WR_RESP only after both handshakes.
REQ-019 WR_RESP: BREADY=1; on BVALID with BRESP!=OKAY SHALL set err and go to FINISH; else index++; after the last index go to RD_ADDR (macro on) or FINISH (macro off).
REQ-020 RD_ADDR: ARVALID held until ARREADY, then RD_DATA; RD_DATA: RREADY=1, consume one beat.
REQ-021 RD_DATA: RRESP!=OKAY SHALL set err and go to FINISH; otherwise wrap index 0..NUM_REGS-1 and finish after the last.
REQ-022 FINISH: done=1 for exactly one cycle, busy=0 in that cycle, then IDLE.
REQ-023 At most one transaction SHALL be outstanding; VALID signals SHALL never drop before READY.
REQ-024 READY signals asserted by the slave before VALID SHALL complete the handshake in the first VALID cycle (zero-wait, 1 cycle per channel).

Reset
REQ-025 ARESETN low SHALL asynchronously force: state=IDLE, all VALID/READY outputs 0, busy=done=err=0, index=0, addresses/WDATA=0.
REQ-026 Reset mid-transaction SHALL abandon it with no recovery; the bench SHALL also reset the slave.

Configuration
REQ-027 Macro AXIL_CFG_READBACK_EN defined: after writes, SHALL read back each register and compare RDATA to shadow; mismatch sets err and goes to FINISH.
REQ-028 Macro undefined: RD_ADDR/RD_DATA logic absent, ARVALID=RREADY=0 constant, sequence ends after last BRESP.

Structure
REQ-029 Package axil_cfg_seq_pkg SHALL hold the FSM state enum and AXI_RESP_OKAY=2'b00 constant.
REQ-030 Single module; no sub-module (AW/W acceptance tracking is two local flags).

Verification
REQ-031 NUM_REGS=4, cfg={4,3,2,1}, zero-wait slave -> writes 0x1@0x0,0x2@0x4,0x3@0x8,0x4@0xC; readback matches; done pulse, err=0.
REQ-032 AWREADY delayed 3 cycles, WREADY immediate -> WVALID high 1 cycle, AWVALID high 4 cycles, exactly one write per register.
REQ-033 Slave BRESP=SLVERR on register 2 -> err=1, done pulse, no write to 0xC, ARVALID never asserted.
REQ-034 Slave register 1 stuck at 0 -> macro on: err=1 after read of 0x4; macro off: err=0, no AR traffic.
REQ-035 start asserted again while busy -> ignored, single sequence; ARESETN low during WR_RESP -> next cycle all VALID=0, busy=0, state IDLE.
